axi4_rdata_ahb_resp: RTL and testbench
======================================

Name: axi4_rdata_ahb_resp

Overview:
Read-data return stage downstream of the AHB-to-AXI4 read address controller. Accepts AXI4 R-channel beats into a small FIFO and presents them to the AHB master as HRDATA/HREADYOUT/HRESP. Produces the two-cycle AHB ERROR response for SLVERR/DECERR beats. On undefined-length burst termination it drains, and discards, R beats still outstanding up to RLAST.

Parameters:
DATA_WIDTH, 32, width of RDATA/HRDATA (32/64/128)
FIFO_DEPTH, 2, R-beat buffer entries; power of 2, range 2..16
LVL_WIDTH, 2, width of rd_fifo_level; must equal clog2(FIFO_DEPTH)+1

Ports:
ACLK  in  1  clock
sysReset  in  1  asynchronous active-low reset
int_masterRDATA  in  DATA_WIDTH  AXI read data
int_masterRRESP  in  2  AXI read response
int_masterRLAST  in  1  AXI last beat
int_masterRVALID  in  1  AXI read valid
int_masterRREADY  out  1  AXI read ready
ahb_rd_dphase  in  1  AHB read data phase active this cycle; wants one beat
ahb_rd_flush  in  1  single-cycle pulse: undefined burst terminated
MASTER_HRDATA  out  DATA_WIDTH  AHB read data
MASTER_HREADYOUT  out  1  AHB ready
MASTER_HRESP  out  1  AHB response; 1 = ERROR
rd_flush_busy  out  1  drain in progress
rd_fifo_level  out  LVL_WIDTH  current FIFO occupancy

Behaviour:
- Clocking and reset: one clock, ACLK. Asynchronous active-low reset, sysReset.
- Reset values: FIFO empty; level 0; state IDLE; burst_open 0; RREADY 1; HREADYOUT 1; HRESP 0; HRDATA 0.
- FIFO entries are {RDATA, RRESP[1], RLAST}. Push when RVALID & RREADY and state is not DRAIN.
- RREADY:
  - In IDLE, ERR1 and ERR2: RREADY = (level != FIFO_DEPTH), combinational from the registered count.
  - In DRAIN: RREADY = 1.
- burst_open: set on an accepted beat with RLAST=0; cleared on an accepted beat with RLAST=1.
- HRDATA: head entry data when the FIFO is non-empty, else 0. Combinational from head.
- IDLE, AHB side:
  - dphase & empty: HREADYOUT=0, HRESP=0 (wait state).
  - dphase & head OKAY: HREADYOUT=1, HRESP=0, pop the head the same cycle. Latency is zero when data is already buffered.
  - dphase & head error (RRESP[1]=1): go to ERR1.
  - No dphase: HREADYOUT=1, HRESP=0, no pop.
- ERR1: HRESP=1, HREADYOUT=0, pop the head. Next state is ERR2.
- ERR2: HRESP=1, HREADYOUT=1. Next state is IDLE.
- ERR1→ERR2 is unconditional, including when flush is asserted. A flush arriving during ERR1 is held pending and acted on in ERR2.
- Flush, when acted on in IDLE or ERR2:
  - FIFO is cleared and level goes to 0 on the next edge.
  - A beat accepted in the same cycle is discarded, but still updates burst_open.
  - If burst_open is still 1 after that update, go to DRAIN; otherwise stay in, or return to, IDLE.
  - Flush takes priority over a push or pop in the same cycle.
- DRAIN:
  - Beats are discarded. rd_flush_busy=1. HREADYOUT=1 and HRESP=0 unless dphase, in which case HREADYOUT=0.
  - Exit to IDLE on RVALID & RLAST, which also clears burst_open.
  - A flush received during DRAIN is ignored.
- Push and pop in the same cycle: level unchanged, and the pointers wrap modulo FIFO_DEPTH.
- A full FIFO holds RREADY=0. A pop while full re-asserts RREADY on the next cycle.
- rd_flush_busy = (state == DRAIN).
- Reset mid-burst returns every register to its reset value immediately, with no drain.

Test Plan:
- Reset, then 4 beats D0..D3 OKAY (RLAST on D3) with dphase held high → HRDATA D0..D3 on consecutive cycles, HREADYOUT=1 each cycle, level ends 0, burst_open 0.
- FIFO_DEPTH=2, RVALID held with 4 beats, dphase low for 3 cycles → RREADY falls after 2 accepts and level=2. With dphase high, it re-rises the cycle after the first pop, and all 4 beats are delivered in order.
- Beat with RRESP=2'b10 at head, dphase → cycle n: HRESP=1, HREADYOUT=0; cycle n+1: HRESP=1, HREADYOUT=1; the entry is popped exactly once and the next beat is served normally.
- 8-beat burst, flush after 2 beats consumed and 2 buffered → level 0 next cycle, rd_flush_busy=1, remaining 4 beats accepted with RREADY=1 and never seen on HRDATA, busy clears after RLAST.
- Flush in the same cycle as an accepted RLAST beat → beat discarded, no DRAIN entered, rd_flush_busy stays 0.
- Flush in ERR1 with burst_open=1 → ERR2 still completes (HRESP=1, HREADYOUT=1), then DRAIN until RLAST.

Source files
------------

// File: rtl/axi4_rdata_ahb_resp.sv
// AXI4 R-channel to AHB read-data return stage: buffers R beats, serves AHB data
// phases, generates the two-cycle ERROR response and drains beats after a flush.
module axi4_rdata_ahb_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int LVL_WIDTH  = 2
) (
  input  logic                  ACLK,
  input  logic                  sysReset,
  input  logic [DATA_WIDTH-1:0] int_masterRDATA,
  input  logic [1:0]            int_masterRRESP,
  input  logic                  int_masterRLAST,
  input  logic                  int_masterRVALID,
  output logic                  int_masterRREADY,
  input  logic                  ahb_rd_dphase,
  input  logic                  ahb_rd_flush,
  output logic [DATA_WIDTH-1:0] MASTER_HRDATA,
  output logic                  MASTER_HREADYOUT,
  output logic                  MASTER_HRESP,
  output logic                  rd_flush_busy,
  output logic [LVL_WIDTH-1:0]  rd_fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = DATA_WIDTH + 2;
  localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ERR1  = 2'd1;
  localparam logic [1:0] ST_ERR2  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 burst_open_q, burst_open_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [LVL_WIDTH-1:0] level_q, level_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]     mem_d [FIFO_DEPTH];

  logic [ENT_W-1:0] head;
  logic empty, full, head_err, accept, push, pop, clear, flush_act;
  logic unused_head_last;

  assign empty            = (level_q == '0);
  assign full             = (level_q == LVL_FULL);
  assign head             = mem_q[rd_ptr_q];
  assign head_err         = head[1];
  assign unused_head_last = head[0];

  // Handshake: an R beat transfers on any cycle where RVALID and RREADY are both
  // high. RREADY is derived from registered state only and never from RVALID.
  assign int_masterRREADY = (state_q == ST_DRAIN) ? 1'b1 : ~full;
  assign accept           = int_masterRVALID & int_masterRREADY;

  assign MASTER_HRDATA = empty ? '0 : head[ENT_W-1:2];
  assign rd_flush_busy = (state_q == ST_DRAIN);
  assign rd_fifo_level = level_q;

  always_comb begin
    state_d          = state_q;
    pop              = 1'b0;
    clear            = 1'b0;
    MASTER_HREADYOUT = 1'b1;
    MASTER_HRESP     = 1'b0;
    burst_open_d     = accept ? ~int_masterRLAST : burst_open_q;
    flush_pend_d     = (state_q == ST_ERR1) & ahb_rd_flush;
    flush_act        = ((state_q == ST_IDLE) | (state_q == ST_ERR2)) &
                       (ahb_rd_flush | flush_pend_q);

    case (state_q)
      ST_IDLE: begin
        if (ahb_rd_dphase) begin
          if (empty) begin
            MASTER_HREADYOUT = 1'b0;
          end else if (head_err) begin
            // Stall this cycle so the AHB ERROR can be issued as two full cycles
            MASTER_HREADYOUT = 1'b0;
            state_d          = ST_ERR1;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_ERR1: begin
        MASTER_HRESP     = 1'b1;
        MASTER_HREADYOUT = 1'b0;
        pop              = 1'b1;
        state_d          = ST_ERR2;
      end
      ST_ERR2: begin
        MASTER_HRESP = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        MASTER_HREADYOUT = ~ahb_rd_dphase;
        if (int_masterRVALID & int_masterRLAST) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // Flush wins over any push, pop or error transition in the same cycle
    if (flush_act) begin
      clear   = 1'b1;
      pop     = 1'b0;
      state_d = burst_open_d ? ST_DRAIN : ST_IDLE;
    end

    push = accept & (state_q != ST_DRAIN) & ~clear;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {int_masterRDATA, int_masterRRESP[1], int_masterRLAST};
    end

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      level_d  = level_q + LVL_WIDTH'(push) - LVL_WIDTH'(pop);
    end
  end

  always_ff @(posedge ACLK or negedge sysReset) begin
    if (!sysReset) begin
      state_q      <= ST_IDLE;
      burst_open_q <= 1'b0;
      flush_pend_q <= 1'b0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      burst_open_q <= burst_open_d;
      flush_pend_q <= flush_pend_d;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
    end
  end

endmodule

// File: tb/tb_axi4_rdata_ahb_resp.sv
// Bench for axi4_rdata_ahb_resp: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axi4_rdata_ahb_resp;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LW    = 2;

  logic          ACLK = 1'b0;
  logic          sysReset;
  logic [DW-1:0] int_masterRDATA;
  logic [1:0]    int_masterRRESP;
  logic          int_masterRLAST;
  logic          int_masterRVALID;
  logic          int_masterRREADY;
  logic          ahb_rd_dphase;
  logic          ahb_rd_flush;
  logic [DW-1:0] MASTER_HRDATA;
  logic          MASTER_HREADYOUT;
  logic          MASTER_HRESP;
  logic          rd_flush_busy;
  logic [LW-1:0] rd_fifo_level;

  always #5 ACLK = ~ACLK;

  axi4_rdata_ahb_resp #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LVL_WIDTH(LW)) dut (
    .ACLK             (ACLK),
    .sysReset         (sysReset),
    .int_masterRDATA  (int_masterRDATA),
    .int_masterRRESP  (int_masterRRESP),
    .int_masterRLAST  (int_masterRLAST),
    .int_masterRVALID (int_masterRVALID),
    .int_masterRREADY (int_masterRREADY),
    .ahb_rd_dphase    (ahb_rd_dphase),
    .ahb_rd_flush     (ahb_rd_flush),
    .MASTER_HRDATA    (MASTER_HRDATA),
    .MASTER_HREADYOUT (MASTER_HREADYOUT),
    .MASTER_HRESP     (MASTER_HRESP),
    .rd_flush_busy    (rd_flush_busy),
    .rd_fifo_level    (rd_fifo_level)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t         src_q[$];
  beat_t         fifo_m[$];
  logic [DW-1:0] deliv_q[$];
  int            deliv_cyc_q[$];

  bit m_drain, m_pend, m_bo;
  int m_err;  // 0 = normal, 1/2 = first/second cycle of an ERROR response

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;
  bit last_accept;

  logic          s_rready, s_hready, s_hresp, s_busy;
  logic [DW-1:0] s_hrdata;
  logic [LW-1:0] s_level;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  function automatic void model_reset();
    fifo_m.delete();
    m_drain = 0;
    m_pend  = 0;
    m_bo    = 0;
    m_err   = 0;
  endfunction

  // One clock cycle: sample at negedge, compare against model, advance model.
  task automatic step();
    bit e_rready, e_hready, e_hresp, acc, fl, pend_next;
    logic [DW-1:0] e_data;
    beat_t nb;
    @(negedge ACLK);
    cyc_n++;
    s_rready = int_masterRREADY;
    s_hready = MASTER_HREADYOUT;
    s_hresp  = MASTER_HRESP;
    s_busy   = rd_flush_busy;
    s_hrdata = MASTER_HRDATA;
    s_level  = rd_fifo_level;

    e_rready = m_drain || (fifo_m.size() < DEPTH);
    e_hresp  = 0;
    e_hready = 1;
    if (m_drain) e_hready = !ahb_rd_dphase;
    else if (m_err == 1) begin e_hresp = 1; e_hready = 0; end
    else if (m_err == 2) e_hresp = 1;
    else if (ahb_rd_dphase && (fifo_m.size() == 0 || fifo_m[0].resp[1])) e_hready = 0;
    e_data = (fifo_m.size() > 0) ? fifo_m[0].data : '0;

    check("rready", s_rready, e_rready);
    check("hreadyout", s_hready, e_hready);
    check("hresp", s_hresp, e_hresp);
    check("hrdata", s_hrdata, e_data);
    check("level", s_level, fifo_m.size());
    check("flush_busy", s_busy, m_drain);

    if (ahb_rd_dphase && s_hready && !s_hresp && !m_drain && m_err == 0) begin
      deliv_q.push_back(s_hrdata);
      deliv_cyc_q.push_back(cyc_n);
    end

    acc = int_masterRVALID && e_rready;
    last_accept = acc;
    nb = '{int_masterRDATA, int_masterRRESP, int_masterRLAST};
    if (acc) m_bo = !int_masterRLAST;
    fl = !m_drain && (m_err != 1) && (ahb_rd_flush || m_pend);
    pend_next = (m_err == 1) && ahb_rd_flush;

    if (m_drain) begin
      if (int_masterRVALID && int_masterRLAST) m_drain = 0;
    end else if (fl) begin
      fifo_m.delete();
      m_drain = m_bo;
      m_err = 0;
    end else begin
      if (m_err == 1) begin
        void'(fifo_m.pop_front());
        m_err = 2;
      end else if (m_err == 2) begin
        m_err = 0;
      end else if (ahb_rd_dphase && fifo_m.size() > 0) begin
        if (fifo_m[0].resp[1]) m_err = 1;
        else void'(fifo_m.pop_front());
      end
      if (acc) fifo_m.push_back(nb);
    end
    m_pend = pend_next;
    @(posedge ACLK);
    #1;
  endtask

  // AXI source: holds a beat until accepted, then presents the next one.
  task automatic src_next(input int gap);
    if (int_masterRVALID && last_accept) begin
      void'(src_q.pop_front());
      int_masterRVALID = 0;
    end
    if (!int_masterRVALID && src_q.size() > 0 && $urandom_range(0, 99) >= gap) begin
      int_masterRDATA  = src_q[0].data;
      int_masterRRESP  = src_q[0].resp;
      int_masterRLAST  = src_q[0].last;
      int_masterRVALID = 1;
    end
  endtask

  task automatic cyc(input int gap);
    step();
    src_next(gap);
  endtask

  task automatic burst(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) src_q.push_back('{base + DW'(i), 2'b00, (i == n - 1)});
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [1:0] r, input logic l);
    int_masterRDATA  = d;
    int_masterRRESP  = r;
    int_masterRLAST  = l;
    int_masterRVALID = 1;
  endtask

  task automatic do_reset();
    sysReset = 0;
    int_masterRVALID = 0;
    ahb_rd_dphase = 0;
    ahb_rd_flush = 0;
    src_q.delete();
    model_reset();
    last_accept = 0;
    @(negedge ACLK);
    check("rst_rready", int_masterRREADY, 1);
    check("rst_hreadyout", MASTER_HREADYOUT, 1);
    check("rst_hresp", MASTER_HRESP, 0);
    check("rst_hrdata", MASTER_HRDATA, 0);
    check("rst_level", rd_fifo_level, 0);
    check("rst_busy", rd_flush_busy, 0);
    repeat (2) @(posedge ACLK);
    #1;
    sysReset = 1;
  endtask

  initial begin
    int k;
    int_masterRDATA = '0;
    int_masterRRESP = 2'b00;
    int_masterRLAST = 0;
    do_reset();

    // Four OKAY beats with dphase held: delivered back to back
    deliv_q.delete(); deliv_cyc_q.delete();
    burst(4, 32'hD000_0000);
    ahb_rd_dphase = 1;
    src_next(0);
    k = 0;
    while (deliv_q.size() < 4 && k < 40) begin cyc(0); k++; end
    check("t1_done", deliv_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_data", deliv_q[i], 32'hD000_0000 + i);
    check("t1_consecutive", deliv_cyc_q[3] - deliv_cyc_q[0], 3);
    ahb_rd_dphase = 0;
    cyc(0);
    check("t1_level_end", s_level, 0);

    // Backpressure with a full FIFO
    deliv_q.delete();
    burst(4, 32'hB000_0000);
    src_next(0);
    repeat (3) cyc(0);
    check("t2_rready_full", s_rready, 0);
    check("t2_level_full", s_level, 2);
    ahb_rd_dphase = 1;
    cyc(0);
    cyc(0);
    check("t2_rready_rerise", s_rready, 1);
    k = 0;
    while (deliv_q.size() < 4 && k < 40) begin cyc(0); k++; end
    check("t2_done", deliv_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_data", deliv_q[i], 32'hB000_0000 + i);
    ahb_rd_dphase = 0;
    cyc(0);

    // SLVERR beat at head followed by an OKAY beat
    src_q.push_back('{32'hE0E0_E0E0, 2'b10, 1'b0});
    src_q.push_back('{32'h1111_1111, 2'b00, 1'b1});
    src_next(0);
    k = 0;
    while (fifo_m.size() < 2 && k < 20) begin cyc(0); k++; end
    check("t3_buffered", fifo_m.size(), 2);
    ahb_rd_dphase = 1;
    step();
    check("t3_detect_hready", s_hready, 0);
    check("t3_detect_hresp", s_hresp, 0);
    step();
    check("t3_err1_hresp", s_hresp, 1);
    check("t3_err1_hready", s_hready, 0);
    step();
    check("t3_err2_hresp", s_hresp, 1);
    check("t3_err2_hready", s_hready, 1);
    check("t3_err2_level", s_level, 1);
    step();
    check("t3_next_hready", s_hready, 1);
    check("t3_next_data", s_hrdata, 32'h1111_1111);
    ahb_rd_dphase = 0;
    step();

    // Flush mid 8-beat burst: 2 consumed, 2 buffered, 4 drained
    deliv_q.delete();
    burst(8, 32'hF000_0000);
    ahb_rd_dphase = 1;
    src_next(0);
    k = 0;
    while (deliv_q.size() < 2 && k < 30) begin cyc(0); k++; end
    ahb_rd_dphase = 0;
    k = 0;
    while (fifo_m.size() < 2 && k < 20) begin cyc(0); k++; end
    check("t4_buffered", fifo_m.size(), 2);
    ahb_rd_flush = 1;
    cyc(0);
    ahb_rd_flush = 0;
    cyc(0);
    check("t4_level_cleared", s_level, 0);
    check("t4_busy", s_busy, 1);
    k = 0;
    while (src_q.size() > 0 && k < 40) begin cyc(0); k++; end
    cyc(0);
    check("t4_busy_clear", s_busy, 0);
    check("t4_deliv_count", deliv_q.size(), 2);
    check("t4_deliv0", deliv_q[0], 32'hF000_0000);
    check("t4_deliv1", deliv_q[1], 32'hF000_0001);

    // Flush coinciding with an accepted RLAST beat: no drain
    drive_beat(32'hA000_0000, 2'b00, 1'b0);
    step();
    drive_beat(32'hA000_0001, 2'b00, 1'b1);
    ahb_rd_flush = 1;
    step();
    int_masterRVALID = 0;
    ahb_rd_flush = 0;
    step();
    check("t5_busy", s_busy, 0);
    check("t5_level", s_level, 0);
    step();
    check("t5_busy_later", s_busy, 0);

    // Flush during ERR1 with an open burst: ERR2 completes, then drain
    drive_beat(32'hC000_0000, 2'b10, 1'b0);
    step();
    int_masterRVALID = 0;
    ahb_rd_dphase = 1;
    step();
    ahb_rd_flush = 1;
    step();
    check("t6_err1_hresp", s_hresp, 1);
    check("t6_err1_hready", s_hready, 0);
    ahb_rd_flush = 0;
    step();
    check("t6_err2_hresp", s_hresp, 1);
    check("t6_err2_hready", s_hready, 1);
    ahb_rd_dphase = 0;
    step();
    check("t6_drain_busy", s_busy, 1);
    drive_beat(32'hC000_0001, 2'b00, 1'b1);
    step();
    check("t6_drain_rready", s_rready, 1);
    int_masterRVALID = 0;
    step();
    check("t6_busy_clear", s_busy, 0);

    // Randomized traffic with a reset in the middle
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) do_reset();
      if (src_q.size() == 0 && !int_masterRVALID) begin
        int n;
        n = $urandom_range(1, 8);
        for (int b = 0; b < n; b++) begin
          logic [1:0] r;
          r = ($urandom_range(0, 99) < 20) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
          src_q.push_back('{DW'($urandom), r, (b == n - 1)});
        end
      end
      ahb_rd_dphase = ($urandom_range(0, 99) < 60);
      ahb_rd_flush  = !ahb_rd_dphase && ($urandom_range(0, 99) < 3);
      cyc(25);
    end
    ahb_rd_flush = 0;
    ahb_rd_dphase = 1;
    repeat (40) cyc(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
